// File: rtl/nabp_ramp_fir_filter.sv
// Streaming symmetric ramp (Ram-Lak) FIR over one projection line at a time; output lags
// the centre sample by HALF+2 advances, line ends are zero-padded via per-slot tags.
module nabp_ramp_fir_filter #(
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 12,
   parameter int HALF       = 3,
   parameter int COEFF_FRAC = 8,
   parameter logic [(HALF+1)*12-1:0] COEFFS = {-12'sd3, 12'sd0, -12'sd26, 12'sd64}
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_first,
   input  logic                  in_last,
   output logic                  out_valid,
   output logic                  out_first,
   output logic                  out_last,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  busy,
   output logic                  protocol_err
);
   localparam int TAPS = 2*HALF + 1;
   localparam int CW   = 12;
   localparam int PW   = DATA_WIDTH + 2 + CW;
   localparam int SW   = PW + $clog2(HALF+1) + 1;
   localparam int CNTW = $clog2(HALF+3);
   localparam int RSH  = (COEFF_FRAC > 0) ? COEFF_FRAC - 1 : 0;
   localparam logic [CNTW-1:0]      FLUSH_LEN = CNTW'(HALF + 2);
   localparam logic signed [SW-1:0] RND  = SW'((COEFF_FRAC > 0) ? (1 << RSH) : 0);
   localparam logic signed [SW-1:0] OMAX = SW'((1 << (OUT_WIDTH-1)) - 1);
   localparam logic signed [SW-1:0] OMIN = ~OMAX;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            accept, advance, start, viol, stray, shift_tag;

   logic [TAPS-1:0]                 tag_q, first_q, last_q;
   logic [TAPS-1:0][DATA_WIDTH-1:0] data_q;
   logic [HALF:0][PW-1:0]           prod_d, prod_q;
   logic                            s1_tag, s1_first, s1_last;
   logic [OUT_WIDTH-1:0]            sat_d;

   assign in_ready  = reset_n && (state_q != FLUSH);
   assign busy      = (state_q != IDLE);
   assign accept    = in_valid && in_ready;
   assign advance   = accept || (state_q == FLUSH);
   assign shift_tag = accept && !stray;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start   = 1'b0;
      viol    = 1'b0;
      stray   = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            if (in_first) begin
               start   = 1'b1;
               state_d = in_last ? FLUSH : RUN;
            end else begin
               stray = 1'b1;
            end
         end
         RUN: if (accept) begin
            start = in_first;
            viol  = in_first;
            if (in_last) state_d = FLUSH;
         end
         FLUSH: begin
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == FLUSH && state_q != FLUSH) cnt_d = FLUSH_LEN;
   end

   // Stage 1: untagged slots read as zero, symmetric pairs pre-added before the multiply.
   always_comb begin
      logic [TAPS-1:0][DATA_WIDTH-1:0] x;
      logic [DATA_WIDTH:0]             p;
      logic signed [PW-1:0]            a, h;
      x      = '0;
      p      = '0;
      a      = '0;
      h      = '0;
      prod_d = '0;
      for (int i = 0; i < TAPS; i++) x[i] = tag_q[i] ? data_q[i] : '0;
      for (int k = 0; k <= HALF; k++) begin
         p = (k == 0) ? {1'b0, x[HALF]} : {1'b0, x[HALF-k]} + {1'b0, x[HALF+k]};
         a = PW'(p);
         h = PW'($signed(COEFFS[k*CW +: CW]));
         prod_d[k] = a * h;
      end
   end

   // Stage 2: full-precision sum, round half up, scale down, clamp to the output range.
   always_comb begin
      logic signed [SW-1:0] acc;
      acc = RND;
      for (int k = 0; k <= HALF; k++) acc = acc + SW'($signed(prod_q[k]));
      acc = acc >>> COEFF_FRAC;
      if (acc > OMAX)      sat_d = OMAX[OUT_WIDTH-1:0];
      else if (acc < OMIN) sat_d = OMIN[OUT_WIDTH-1:0];
      else                 sat_d = acc[OUT_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         tag_q        <= '0;
         first_q      <= '0;
         last_q       <= '0;
         data_q       <= '0;
         prod_q       <= '0;
         s1_tag       <= 1'b0;
         s1_first     <= 1'b0;
         s1_last      <= 1'b0;
         out_valid    <= 1'b0;
         out_first    <= 1'b0;
         out_last     <= 1'b0;
         out_data     <= '0;
         protocol_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         out_valid <= 1'b0;
         if (viol || stray) protocol_err <= 1'b1;
         if (advance) begin
            // A line start invalidates everything older in the delay line.
            tag_q     <= {tag_q[TAPS-2:0] & {(TAPS-1){!start}}, shift_tag};
            first_q   <= {first_q[TAPS-2:0], shift_tag & in_first};
            last_q    <= {last_q[TAPS-2:0], shift_tag & in_last};
            data_q    <= {data_q[TAPS-2:0], in_data & {DATA_WIDTH{shift_tag}}};
            prod_q    <= prod_d;
            s1_tag    <= tag_q[HALF] && !viol;
            s1_first  <= first_q[HALF];
            s1_last   <= last_q[HALF];
            out_valid <= s1_tag && !viol;
            out_first <= s1_first;
            out_last  <= s1_last;
            out_data  <= sat_d;
         end
      end
   end
endmodule

// File: tb/tb_nabp_ramp_fir_filter.sv
// Bench for nabp_ramp_fir_filter: directed lines push hand-computed outputs into a queue,
// an output monitor pops and compares; a second instance runs with COEFF_FRAC=0.
module tb_nabp_ramp_fir_filter;
   typedef struct packed {
      logic signed [11:0] data;
      logic               first;
      logic               last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_first, in_last;
   logic [7:0]  in_data;
   logic        in_ready, out_valid, out_first, out_last, busy, protocol_err;
   logic [11:0] out_data;
   logic        v2, f2, l2;
   logic [7:0]  d2;
   logic        rdy2, ov2, of2, ol2, busy2, err2;
   logic [11:0] od2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t_acc = 0;
   int t_out = 0;
   int last_wait = 0;
   exp_t q[$];
   exp_t q2[$];

   logic [7:0] imp_x[9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0};
   int         imp_y[9] = '{0, -1, 0, -10, 25, -10, 0, -1, 0};
   int         cst_y[8] = '{35, 9, 9, 6, 6, 9, 9, 35};
   int         a_y[4]   = '{35, 12, 12, 35};
   logic [7:0] b_x[4]   = '{8'd0, 8'd100, 8'd0, 8'd0};
   int         b_y[4]   = '{-10, 25, -10, 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nabp_ramp_fir_filter dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
      .out_data(out_data), .busy(busy), .protocol_err(protocol_err)
   );

   nabp_ramp_fir_filter #(.COEFF_FRAC(0)) dut_frac0 (
      .clk(clk), .reset_n(reset_n), .in_valid(v2), .in_ready(rdy2),
      .in_data(d2), .in_first(f2), .in_last(l2),
      .out_valid(ov2), .out_first(of2), .out_last(ol2),
      .out_data(od2), .busy(busy2), .protocol_err(err2)
   );

   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got data=%0d first=%0b last=%0b required no output",
                     $signed(out_data), out_first, out_last);
         end else begin
            e = q.pop_front();
            if (out_data !== e.data || out_first !== e.first || out_last !== e.last) begin
               errors++;
               $display("FAIL out_sample got data=%0d first=%0b last=%0b required data=%0d first=%0b last=%0b",
                        $signed(out_data), out_first, out_last, e.data, e.first, e.last);
            end
         end
         if (out_first) t_out = cyc;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (ov2) begin
         checks++;
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output_frac0 got data=%0d required no output", $signed(od2));
         end else begin
            e = q2.pop_front();
            if (od2 !== e.data || of2 !== e.first || ol2 !== e.last) begin
               errors++;
               $display("FAIL out_sample_frac0 got data=%0d first=%0b last=%0b required data=%0d first=%0b last=%0b",
                        $signed(od2), of2, ol2, e.data, e.first, e.last);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, want);
      end
   endtask

   task automatic push_exp(input int d, input bit f, input bit l);
      exp_t e;
      e.data  = 12'(d);
      e.first = f;
      e.last  = l;
      q.push_back(e);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'd0;
   endtask

   task automatic send_sample(input logic [7:0] d, input bit f, input bit l);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_first = f;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && w < 40) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout got in_ready=0 required 1 within 40 cycles");
      end
      @(posedge clk);
      #1;
      last_wait = w;
      if (f) t_acc = cyc;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while ((q.size() != 0 || q2.size() != 0) && w < 60) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("drain", q.size() + q2.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no finish required finish before 200000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      v2 = 1'b0; f2 = 1'b0; l2 = 1'b0; d2 = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ready_in_reset", in_ready, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_protocol_err", protocol_err, 0);
      @(posedge clk);
      #1;

      // impulse line, continuous valid
      for (int i = 0; i < 9; i++) push_exp(imp_y[i], i == 0, i == 8);
      for (int i = 0; i < 9; i++) send_sample(imp_x[i], i == 0, i == 8);
      idle_inputs();
      wait_drain();
      check("impulse_latency", t_out - t_acc, 5);

      // constant line exercises zero padding at both ends
      for (int i = 0; i < 8; i++) push_exp(cst_y[i], i == 0, i == 7);
      for (int i = 0; i < 8; i++) send_sample(8'd255, i == 0, i == 7);
      idle_inputs();
      wait_drain();

      // back-to-back lines with valid held through the flush
      for (int i = 0; i < 4; i++) push_exp(a_y[i], i == 0, i == 3);
      for (int i = 0; i < 4; i++) push_exp(b_y[i], i == 0, i == 3);
      for (int i = 0; i < 4; i++) send_sample(8'd255, i == 0, i == 3);
      for (int i = 0; i < 4; i++) begin
         send_sample(b_x[i], i == 0, i == 3);
         if (i == 0) check("flush_ready_low_cycles", last_wait, 5);
      end
      idle_inputs();
      wait_drain();

      // impulse line with a 3-cycle valid gap after x[2]
      for (int i = 0; i < 9; i++) push_exp(imp_y[i], i == 0, i == 8);
      for (int i = 0; i < 9; i++) begin
         if (i == 3) begin
            idle_inputs();
            repeat (3) @(posedge clk);
            #1;
         end
         send_sample(imp_x[i], i == 0, i == 8);
      end
      idle_inputs();
      wait_drain();
      check("stall_latency", t_out - t_acc, 8);

      // single-sample lines: saturation at COEFF_FRAC=0, plain scaling at default
      begin
         exp_t e;
         e.data = 12'sd2047; e.first = 1'b1; e.last = 1'b1;
         q2.push_back(e);
      end
      v2 = 1'b1; d2 = 8'd255; f2 = 1'b1; l2 = 1'b1;
      @(negedge clk);
      check("frac0_in_ready", rdy2, 1);
      @(posedge clk);
      #1;
      v2 = 1'b0; f2 = 1'b0; l2 = 1'b0;
      push_exp(64, 1'b1, 1'b1);
      send_sample(8'd255, 1'b1, 1'b1);
      idle_inputs();
      wait_drain();
      check("no_err_on_clean_lines", protocol_err, 0);

      // in_first at index 3: partial line dropped, new line processed
      for (int i = 0; i < 4; i++) push_exp(b_y[i], i == 0, i == 3);
      for (int i = 0; i < 3; i++) send_sample(8'd200, i == 0, 1'b0);
      for (int i = 0; i < 4; i++) send_sample(b_x[i], i == 0, i == 3);
      idle_inputs();
      wait_drain();
      check("protocol_err_restart", protocol_err, 1);

      // reset asserted while flushing a line
      send_sample(8'd255, 1'b1, 1'b1);
      idle_inputs();
      check("busy_in_flush", busy, 1);
      reset_n = 1'b0;
      @(negedge clk);
      check("ready_low_in_reset", in_ready, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("post_reset_busy", busy, 0);
      check("post_reset_out_valid", out_valid, 0);
      check("post_reset_in_ready", in_ready, 1);
      check("post_reset_protocol_err", protocol_err, 0);
      repeat (8) @(posedge clk);
      #1;

      // stray sample in IDLE without in_first
      in_valid = 1'b1; in_data = 8'd77; in_first = 1'b0; in_last = 1'b0;
      @(posedge clk);
      #1;
      idle_inputs();
      @(negedge clk);
      check("protocol_err_stray", protocol_err, 1);
      repeat (8) @(posedge clk);
      #1;
      check("final_queue_empty", q.size() + q2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
